// File: rtl/multicycle_control_sequencer.sv
// multicycle_control_sequencer
// Multicycle control FSM for the 8-bit processor. Steps one 16-bit instruction
// through FETCH, DECODE, EXEC, MEM and WB, handshakes with instruction/data
// memories that may insert wait states, and drives the datapath control strobes.
module multicycle_control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        dmem_ready,
    input  logic        equality,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        AluSrc,
    output logic        MemtoReg,
    output logic        r2Chooser,
    output logic [2:0]  AluControl,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Instruction class derived from the captured opcode/funct.
    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_ADDI  = 3'd1,
        K_LW    = 3'd2,
        K_SW    = 3'd3,
        K_BEQ   = 3'd4,
        K_J     = 3'd5,
        K_BAD   = 3'd6
    } kind_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b0010;

    state_t      state_q;
    state_t      after_retire;
    logic [3:0]  op_p0;
    logic [2:0]  funct_p0;
    logic        illegal_q;
    logic [15:0] retired_q;
    kind_t       kind;
    logic        fetch_done;
    logic        retire;
    logic        unused_rdata;

    function automatic kind_t classify(input logic [3:0] op, input logic [2:0] funct);
        kind_t k;
        case (op)
            OP_RTYPE: k = (funct == 3'b110) ? K_BAD : K_RTYPE;
            OP_ADDI:  k = K_ADDI;
            OP_LW:    k = K_LW;
            OP_SW:    k = K_SW;
            OP_BEQ:   k = K_BEQ;
            OP_J:     k = K_J;
            default:  k = K_BAD;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_code(input kind_t k, input logic [2:0] funct);
        logic [2:0] code;
        code = 3'b000;
        if (k == K_BEQ) begin
            code = 3'b111;
        end else if (k == K_RTYPE) begin
            case (funct)
                3'b000:  code = 3'b000;  // ADD
                3'b010:  code = 3'b001;  // SUB
                3'b100:  code = 3'b010;  // AND
                3'b101:  code = 3'b011;  // OR
                3'b001:  code = 3'b100;  // EOR
                3'b011:  code = 3'b101;  // BIC
                3'b111:  code = 3'b110;  // RSB
                default: code = 3'b000;
            endcase
        end
        return code;
    endfunction

    // Only the opcode and funct fields steer control; the rest belongs to the datapath.
    assign unused_rdata = ^imem_rdata[11:3];

    assign kind         = classify(op_p0, funct_p0);
    assign fetch_done   = (state_q == S_FETCH) && imem_ready;
    assign after_retire = run ? S_FETCH : S_IDLE;

    // Retire strobe: the final cycle of each instruction class.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE: retire = (kind == K_J);
            S_EXEC:   retire = (kind == K_BEQ);
            S_MEM:    retire = (kind == K_SW) && dmem_ready;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    // Opcode and funct latched on the accepted fetch; data-only, so no reset.
    always_ff @(posedge clk) begin
        if (fetch_done) begin
            op_p0    <= imem_rdata[15:12];
            funct_p0 <= imem_rdata[2:0];
        end
    end

    // Sequencer state, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (kind == K_BAD) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else if (kind == K_J) begin
                        state_q <= after_retire;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if ((kind == K_LW) || (kind == K_SW)) begin
                        state_q <= S_MEM;
                    end else if (kind == K_BEQ) begin
                        state_q <= after_retire;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= (kind == K_LW) ? S_WB : after_retire;
                    end
                end
                S_WB: begin
                    state_q <= after_retire;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Control strobes decoded from the current state and the captured instruction.
    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        AluSrc     = 1'b0;
        MemtoReg   = 1'b0;
        r2Chooser  = 1'b0;
        AluControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
                pc_en    = imem_ready;
            end
            S_DECODE: begin
                if (kind == K_J) begin
                    pc_en  = 1'b1;
                    pc_src = 2'b10;
                end
            end
            S_EXEC: begin
                AluControl = alu_code(kind, funct_p0);
                AluSrc     = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW);
                r2Chooser  = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW) ||
                             (kind == K_BEQ);
                if ((kind == K_BEQ) && equality) begin
                    pc_en  = 1'b1;
                    pc_src = 2'b01;
                end
            end
            S_MEM: begin
                MemRead  = (kind == K_LW);
                MemWrite = (kind == K_SW);
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (kind == K_LW);
            end
            default: begin
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
`timescale 1ns/1ps
// Bench for multicycle_control_sequencer: a directed vector table, hand-written
// reset/trap sequences and a random instruction stream, each checked cycle by
// cycle against a per-instruction expected trace built from the instruction word.
module tb_multicycle_control_sequencer;

    localparam int KR = 0, KADDI = 1, KLW = 2, KSW = 3, KBEQ = 4, KJ = 5, KBAD = 6;

    logic        clk = 1'b0;
    logic        reset, run, imem_req, imem_ready, dmem_ready, equality;
    logic        ir_load, pc_en, RegWrite, MemRead, MemWrite, AluSrc, MemtoReg, r2Chooser, illegal;
    logic [15:0] imem_rdata, retired;
    logic [1:0]  pc_src;
    logic [2:0]  AluControl, state;

    always #5 clk = ~clk;

    multicycle_control_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_ready(dmem_ready), .equality(equality),
        .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .AluSrc(AluSrc), .MemtoReg(MemtoReg), .r2Chooser(r2Chooser),
        .AluControl(AluControl), .illegal(illegal), .state(state), .retired(retired)
    );

    // One expected cycle: outputs plus the input values that cycle requires.
    typedef struct packed {
        logic [17:0] out;
        logic ifix, iv, dfix, dv, efix, ev;
    } cyc_t;

    typedef struct {
        logic [15:0] w;
        int          fw;
        int          mw;
        bit          eq;
        bit          runl;
        int          lat;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   exp_ret;
    bit   exp_idle;
    int   alu_tab [8];
    cyc_t plan [$];
    vec_t vecs [16];

    function automatic logic [17:0] ovec(int st, int req, int irl, int pce, int pcs, int rw,
                                         int mr, int mw, int as_, int mtr, int r2, int alu, int ill);
        return {3'(st), 1'(req), 1'(irl), 1'(pce), 2'(pcs), 1'(rw), 1'(mr), 1'(mw),
                1'(as_), 1'(mtr), 1'(r2), 3'(alu), 1'(ill)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {state, imem_req, ir_load, pc_en, pc_src, RegWrite, MemRead, MemWrite,
                AluSrc, MemtoReg, r2Chooser, AluControl, illegal};
    endfunction

    function automatic cyc_t mk(logic [17:0] o, bit ifix, bit iv, bit dfix, bit dv, bit efix, bit ev);
        cyc_t c;
        c.out = o; c.ifix = ifix; c.iv = iv; c.dfix = dfix; c.dv = dv; c.efix = efix; c.ev = ev;
        return c;
    endfunction

    function automatic int kind_of(logic [15:0] w);
        case (w[15:12])
            4'h0:    return (w[2:0] == 3'b110) ? KBAD : KR;
            4'h4:    return KADDI;
            4'hB:    return KLW;
            4'hF:    return KSW;
            4'h8:    return KBEQ;
            4'h2:    return KJ;
            default: return KBAD;
        endcase
    endfunction

    function automatic int lat_of(int k);
        if (k == KJ)  return 2;
        if (k == KBEQ) return 3;
        if (k == KLW) return 5;
        return 4;
    endfunction

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic drive_random();
        imem_ready = 1'($urandom);
        imem_rdata = 16'($urandom);
        dmem_ready = 1'($urandom);
        equality   = 1'($urandom);
    endtask

    // Expected trace of one instruction, from the first FETCH cycle to retire (or into TRAP).
    task automatic build(input logic [15:0] w, input int fw, input int mw, input bit eqv);
        int k, alu, as_, r2, pce, isl, iss;
        plan.delete();
        k = kind_of(w);
        for (int i = 0; i < fw; i++)
            plan.push_back(mk(ovec(1,1,0,0,0,0,0,0,0,0,0,0,0), 1, 0, 0, 0, 0, 0));
        plan.push_back(mk(ovec(1,1,1,1,0,0,0,0,0,0,0,0,0), 1, 1, 0, 0, 0, 0));
        if (k == KJ) plan.push_back(mk(ovec(2,0,0,1,2,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0, 0));
        else         plan.push_back(mk(ovec(2,0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0, 0));
        if (k == KBAD) begin
            for (int i = 0; i < 4; i++)
                plan.push_back(mk(ovec(6,0,0,0,0,0,0,0,0,0,0,0,1), 0, 0, 0, 0, 0, 0));
            return;
        end
        if (k == KJ) return;
        alu = (k == KR) ? alu_tab[w[2:0]] : ((k == KBEQ) ? 7 : 0);
        as_ = (k == KADDI || k == KLW || k == KSW) ? 1 : 0;
        r2  = (k != KR) ? 1 : 0;
        pce = (k == KBEQ && eqv) ? 1 : 0;
        plan.push_back(mk(ovec(3,0,0,pce,pce,0,0,0,as_,0,r2,alu,0), 0, 0, 0, 0, 1, eqv));
        isl = (k == KLW) ? 1 : 0;
        iss = (k == KSW) ? 1 : 0;
        if (isl == 1 || iss == 1) begin
            for (int i = 0; i < mw; i++)
                plan.push_back(mk(ovec(4,0,0,0,0,0,isl,iss,0,0,0,0,0), 0, 0, 1, 0, 0, 0));
            plan.push_back(mk(ovec(4,0,0,0,0,0,isl,iss,0,0,0,0,0), 0, 0, 1, 1, 0, 0));
        end
        if (k == KR || k == KADDI || k == KLW)
            plan.push_back(mk(ovec(5,0,0,0,0,1,0,0,0,isl,0,0,0), 0, 0, 0, 0, 0, 0));
    endtask

    task automatic exec_instr(input string nm, input logic [15:0] w, input int fw, input int mw,
                              input bit eqv, input bit runl, output int lat);
        lat = 0;
        if (exp_idle) begin
            for (int r = 0; r < 2; r++) begin
                @(negedge clk);
                run = (r == 1);
                drive_random();
                #1;
                check($sformatf("%s idle%0d", nm, r), {retired, dut_vec()},
                      {16'(exp_ret), ovec(0,0,0,0,0,0,0,0,0,0,0,0,0)});
            end
        end
        build(w, fw, mw, eqv);
        foreach (plan[i]) begin
            @(negedge clk);
            run        = runl;
            imem_ready = plan[i].ifix ? plan[i].iv : 1'($urandom);
            imem_rdata = (plan[i].ifix && plan[i].iv) ? w : 16'($urandom);
            dmem_ready = plan[i].dfix ? plan[i].dv : 1'($urandom);
            equality   = plan[i].efix ? plan[i].ev : 1'($urandom);
            #1;
            if (state != 3'd0) lat++;
            check($sformatf("%s cyc%0d", nm, i), {retired, dut_vec()}, {16'(exp_ret), plan[i].out});
        end
        if (kind_of(w) != KBAD) begin
            exp_ret  = (exp_ret + 1) & 32'hFFFF;
            exp_idle = !runl;
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        drive_random();
        @(negedge clk);
        #1;
        check(nm, {retired, dut_vec()}, {16'h0000, ovec(0,0,0,0,0,0,0,0,0,0,0,0,0)});
        reset    = 1'b0;
        run      = 1'b0;
        exp_ret  = 0;
        exp_idle = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, k, fw, mw, sel;
        bit          eqv, runl;
        logic [15:0] w, rnd;
        logic [3:0]  op;
        logic [2:0]  f;

        alu_tab[0] = 0; alu_tab[1] = 4; alu_tab[2] = 1; alu_tab[3] = 5;
        alu_tab[4] = 2; alu_tab[5] = 3; alu_tab[6] = 0; alu_tab[7] = 6;

        vecs[0]  = '{16'h0120, 0, 0, 1'b0, 1'b1, 4};
        vecs[1]  = '{16'hB123, 0, 3, 1'b0, 1'b1, 8};
        vecs[2]  = '{16'h8123, 0, 0, 1'b1, 1'b1, 3};
        vecs[3]  = '{16'h8123, 0, 0, 1'b0, 1'b1, 3};
        vecs[4]  = '{16'h2040, 0, 0, 1'b0, 1'b1, 2};
        vecs[5]  = '{16'h0122, 2, 0, 1'b0, 1'b1, 6};
        vecs[6]  = '{16'h0124, 0, 0, 1'b0, 1'b1, 4};
        vecs[7]  = '{16'h0125, 0, 0, 1'b0, 1'b1, 4};
        vecs[8]  = '{16'h0121, 1, 0, 1'b0, 1'b1, 5};
        vecs[9]  = '{16'h0123, 0, 0, 1'b0, 1'b1, 4};
        vecs[10] = '{16'h0127, 0, 0, 1'b0, 1'b0, 4};
        vecs[11] = '{16'h4567, 0, 0, 1'b0, 1'b1, 4};
        vecs[12] = '{16'hF123, 1, 2, 1'b0, 1'b0, 7};
        vecs[13] = '{16'hB0FF, 0, 0, 1'b0, 1'b1, 5};
        vecs[14] = '{16'h2FFF, 0, 0, 1'b0, 1'b0, 2};
        vecs[15] = '{16'h8FF0, 3, 1, 1'b1, 1'b1, 6};

        reset = 1'b1;
        run   = 1'b0;
        drive_random();
        do_reset("reset_init");

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            exec_instr($sformatf("vec%0d", i), vecs[i].w, vecs[i].fw, vecs[i].mw,
                       vecs[i].eq, vecs[i].runl, lat);
            check($sformatf("vec%0d latency", i), 34'(lat), 34'(vecs[i].lat));
        end

        // Reset in the middle of an SW stalled in MEM.
        if (exp_idle) begin
            @(negedge clk); run = 1'b1; drive_random(); #1;
        end
        @(negedge clk);
        run = 1'b1; imem_ready = 1'b1; imem_rdata = 16'hF123; dmem_ready = 1'b0; #1;
        check("sw_rst fetch", {retired, dut_vec()}, {16'(exp_ret), ovec(1,1,1,1,0,0,0,0,0,0,0,0,0)});
        @(negedge clk); imem_ready = 1'b0; #1;
        check("sw_rst decode", {retired, dut_vec()}, {16'(exp_ret), ovec(2,0,0,0,0,0,0,0,0,0,0,0,0)});
        @(negedge clk); #1;
        check("sw_rst exec", {retired, dut_vec()}, {16'(exp_ret), ovec(3,0,0,0,0,0,0,0,1,0,1,0,0)});
        @(negedge clk); dmem_ready = 1'b0; #1;
        check("sw_rst mem", {retired, dut_vec()}, {16'(exp_ret), ovec(4,0,0,0,0,0,0,1,0,0,0,0,0)});
        @(negedge clk); reset = 1'b1; dmem_ready = 1'b0; #1;
        check("sw_rst mem hold", {retired, dut_vec()}, {16'(exp_ret), ovec(4,0,0,0,0,0,0,1,0,0,0,0,0)});
        @(negedge clk); #1;
        check("sw_rst after reset", {retired, dut_vec()}, {16'h0000, ovec(0,0,0,0,0,0,0,0,0,0,0,0,0)});
        reset = 1'b0; run = 1'b1; imem_ready = 1'b0;
        @(negedge clk); imem_ready = 1'b0; #1;
        check("sw_rst refetch", {retired, dut_vec()}, {16'h0000, ovec(1,1,0,0,0,0,0,0,0,0,0,0,0)});
        exp_ret  = 0;
        exp_idle = 1'b0;

        // Illegal encodings: funct 110, then an unused opcode.
        exec_instr("bad_funct", 16'h0006, 0, 0, 1'b0, 1'b1, lat);
        do_reset("bad_funct reset");
        exec_instr("bad_op", 16'h5000, 1, 0, 1'b0, 1'b1, lat);
        do_reset("bad_op reset");

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 15);
            rnd = 16'($urandom);
            if (sel <= 2) begin
                f = rnd[2:0];
                if (f == 3'b110) f = 3'b111;
                w = {4'h0, rnd[11:3], f};
            end else if (sel <= 4) w = {4'h4, rnd[11:0]};
            else if (sel <= 6)     w = {4'hB, rnd[11:0]};
            else if (sel <= 8)     w = {4'hF, rnd[11:0]};
            else if (sel <= 11)    w = {4'h8, rnd[11:0]};
            else if (sel <= 13)    w = {4'h2, rnd[11:0]};
            else if (sel == 14) begin
                do op = 4'($urandom); while (op inside {4'h0, 4'h2, 4'h4, 4'h8, 4'hB, 4'hF});
                w = {op, rnd[11:0]};
            end else w = {4'h0, rnd[11:3], 3'b110};
            fw   = $urandom_range(0, 2);
            mw   = $urandom_range(0, 3);
            eqv  = 1'($urandom);
            runl = ($urandom_range(0, 3) != 0);
            k    = kind_of(w);
            if (k == KBAD) runl = 1'b1;
            exec_instr($sformatf("rnd%0d", n), w, fw, mw, eqv, runl, lat);
            if (k == KBAD) do_reset($sformatf("rnd%0d reset", n));
            else check($sformatf("rnd%0d latency", n), 34'(lat),
                       34'(lat_of(k) + fw + ((k == KLW || k == KSW) ? mw : 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
